// File: rtl/cache_fill_fsm_if.sv
// Bundle between one cache_fill_fsm and its cache, pipeline and memory port.
//
// Signalling: there is no ready/valid back-pressure on this bus. A miss is
// offered by holding miss_detected high, and it is taken in any cycle where
// the engine is idle. Memory reads are fire-and-forget: mem_en high for one
// cycle issues one read of memory_address. memory_data_valid high for one
// cycle returns the oldest outstanding read, in issue order. write_data_array
// and write_tag_array are single-cycle write strobes toward the cache arrays.
interface cache_fill_fsm_if #(
  parameter int BLOCK_WORDS = 8
) ();
  localparam int OFF_W = $clog2(BLOCK_WORDS);

  logic             miss_detected;
  logic [15:0]      miss_address;
  logic [15:0]      memory_data;
  logic             memory_data_valid;
  logic             fsm_busy;
  logic             mem_en;
  logic [15:0]      memory_address;
  logic             write_data_array;
  logic [OFF_W-1:0] write_word_offset;
  logic             write_tag_array;
  logic [15:0]      fill_block_addr;
  logic [15:0]      fill_data;
  // Debug view of the engine state: 0 = IDLE, 1 = FILL.
  logic             fsm_state;

  // Cache/pipeline/memory side.
  modport master (
    output miss_detected, miss_address, memory_data, memory_data_valid,
    input  fsm_busy, mem_en, memory_address, write_data_array,
    input  write_word_offset, write_tag_array, fill_block_addr, fill_data,
    input  fsm_state
  );

  // Fill engine side.
  modport slave (
    input  miss_detected, miss_address, memory_data, memory_data_valid,
    output fsm_busy, mem_en, memory_address, write_data_array,
    output write_word_offset, write_tag_array, fill_block_addr, fill_data,
    output fsm_state
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine. On a miss it stalls the pipeline, issues one memory
// read per word of the missing block, writes each returned word into the data
// array, and writes the tag together with the final word. Reads are issued
// back to back while data returns overlap, so the fill takes
// BLOCK_WORDS + memory latency cycles when memory never stalls.
module cache_fill_fsm #(
  parameter int BLOCK_WORDS = 8
) (
  input logic          clk,
  input logic          rst_n,
  cache_fill_fsm_if.slave bus
);
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [CNT_W-1:0] ALL_ISSUED = CNT_W'(BLOCK_WORDS);
  // Byte-offset bits covered by one block (word offset plus byte-in-word).
  localparam logic [15:0] OFF_MASK = 16'(2 * BLOCK_WORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] recv_cnt_q, recv_cnt_d;
  logic [15:0]      block_q, block_d;

  logic             busy;
  logic             mem_en;
  logic [15:0]      mem_addr;
  logic             wr_data;
  logic [OFF_W-1:0] wr_offset;
  logic             wr_tag;

  // State, counters and latched block base; reset drops any fill in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      block_q     <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      block_q     <= block_d;
    end
  end

  // Next state, counter updates and per-cycle outputs.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    block_d     = block_q;
    busy        = 1'b0;
    mem_en      = 1'b0;
    mem_addr    = '0;
    wr_data     = 1'b0;
    wr_offset   = '0;
    wr_tag      = 1'b0;

    case (state_q)
      IDLE: begin
        // Stall in the miss cycle itself; gated so reset forces it low.
        busy = bus.miss_detected & rst_n;
        if (bus.miss_detected) begin
          block_d     = bus.miss_address & ~OFF_MASK;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = FILL;
        end
      end

      FILL: begin
        busy = 1'b1;
        // Issue side: one read per cycle until the whole block is requested.
        if (issue_cnt_q < ALL_ISSUED) begin
          mem_en      = 1'b1;
          mem_addr    = block_q + 16'({issue_cnt_q, 1'b0});
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
        // Receive side: every returned word goes straight into the array.
        wr_data   = bus.memory_data_valid;
        wr_offset = recv_cnt_q[OFF_W-1:0];
        if (bus.memory_data_valid) begin
          recv_cnt_d = recv_cnt_q + 1'b1;
          if (recv_cnt_q == LAST_WORD) begin
            wr_tag  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.fsm_busy          = busy;
  assign bus.mem_en            = mem_en;
  assign bus.memory_address    = mem_addr;
  assign bus.write_data_array  = wr_data;
  assign bus.write_word_offset = wr_offset;
  assign bus.write_tag_array   = wr_tag;
  assign bus.fill_block_addr   = block_q;
  assign bus.fill_data         = bus.memory_data;
  assign bus.fsm_state         = state_q;
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: memory model with programmable return gaps,
// a fill-level reference model that queues the expected reads and array
// writes at miss acceptance, and a monitor that pops them as the engine
// drives its strobes.
module tb_cache_fill_fsm;
  localparam int BW          = 8;
  localparam int MEM_LATENCY = 4;
  localparam int OFF_W       = $clog2(BW);
  localparam int WR_W        = OFF_W + 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cache_fill_fsm_if #(.BLOCK_WORDS(BW)) bus ();

  cache_fill_fsm #(.BLOCK_WORDS(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- memory model ----------------
  logic [15:0] data_tag = 16'hA000;
  int          gap_mode = 0;     // 0: return asap, 1: random gaps, 2: fixed schedule
  logic        inj = 1'b0;       // force a stray valid this cycle
  logic [15:0] pend_addr_q[$];
  int          pend_rdy_q[$];
  int          sched[8] = '{5, 7, 8, 11, 12, 13, 15, 16};

  function automatic logic [15:0] mem_fn(input logic [15:0] addr);
    return data_tag + ((addr >> 1) & 16'(BW - 1));
  endfunction

  // Accept read requests seen in this cycle.
  always @(negedge clk) begin
    if (rst_n && bus.mem_en === 1'b1) begin
      pend_addr_q.push_back(bus.memory_address);
      pend_rdy_q.push_back(cyc + MEM_LATENCY);
    end
  end

  // ---------------- reference model + monitor state ----------------
  logic        m_fill = 1'b0;
  logic [15:0] m_block = '0;
  int          m_issued = 0;
  int          m_recv = 0;
  int          m_acc_cyc = 0;
  int          m_acc_cnt = 0;
  int          tag_count = 0;
  int          last_tag_cyc = 0;
  logic [15:0] exp_addr_q[$];
  logic [WR_W-1:0] exp_wr_q[$];
  logic        exp_wr;
  logic        accept;
  logic [15:0] exp_a;
  logic [WR_W-1:0] exp_w;

  // Drive the memory return for the new cycle.
  always @(posedge clk) begin
    logic rel_ok;
    int   rel;
    #2;
    rel = cyc - m_acc_cyc;
    rel_ok = 1'b1;
    if (gap_mode == 1) rel_ok = ($urandom_range(0, 1) == 1);
    if (gap_mode == 2) begin
      rel_ok = 1'b0;
      for (int i = 0; i < 8; i++) if (sched[i] == rel) rel_ok = 1'b1;
    end
    if (pend_addr_q.size() != 0 && pend_rdy_q[0] <= cyc && rel_ok) begin
      bus.memory_data_valid = 1'b1;
      bus.memory_data       = mem_fn(pend_addr_q.pop_front());
      void'(pend_rdy_q.pop_front());
    end else if (inj) begin
      bus.memory_data_valid = 1'b1;
      bus.memory_data       = 16'($urandom);
    end else begin
      bus.memory_data_valid = 1'b0;
      bus.memory_data       = 16'($urandom);
    end
  end

  // Monitor: compare this cycle, then advance the reference model.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_fill = 1'b0;
      m_block = '0;
      exp_addr_q.delete();
      exp_wr_q.delete();
      check("rst_busy", 32'(bus.fsm_busy), 32'd0);
      check("rst_mem_en", 32'(bus.mem_en), 32'd0);
      check("rst_addr", 32'(bus.memory_address), 32'd0);
      check("rst_wr", 32'(bus.write_data_array), 32'd0);
      check("rst_tag", 32'(bus.write_tag_array), 32'd0);
      check("rst_block", 32'(bus.fill_block_addr), 32'd0);
    end else begin
      accept = !m_fill && bus.miss_detected;
      exp_wr = m_fill && bus.memory_data_valid;
      check("busy", 32'(bus.fsm_busy), 32'(m_fill || bus.miss_detected));
      check("mem_en", 32'(bus.mem_en), 32'(m_fill && m_issued < BW));
      check("wr_strobe", 32'(bus.write_data_array), 32'(exp_wr));
      check("tag_strobe", 32'(bus.write_tag_array), 32'(exp_wr && m_recv == BW - 1));
      if (bus.mem_en === 1'b1) begin
        if (exp_addr_q.size() == 0) fail_now("mem_addr_unexpected");
        else begin
          exp_a = exp_addr_q.pop_front();
          check("mem_addr", 32'(bus.memory_address), 32'(exp_a));
        end
      end else begin
        check("addr_idle_zero", 32'(bus.memory_address), 32'd0);
      end
      if (bus.write_data_array === 1'b1) begin
        if (exp_wr_q.size() == 0) fail_now("array_write_unexpected");
        else begin
          exp_w = exp_wr_q.pop_front();
          check("wr_offset", 32'(bus.write_word_offset), 32'(exp_w[WR_W-1:16]));
          check("wr_data", 32'(bus.fill_data), 32'(exp_w[15:0]));
        end
      end
      if (m_fill) check("block_hold", 32'(bus.fill_block_addr), 32'(m_block));
      if (bus.write_tag_array === 1'b1) begin
        tag_count++;
        last_tag_cyc = cyc;
      end
      // Advance the model.
      if (accept) begin
        m_fill    = 1'b1;
        m_block   = bus.miss_address & ~16'(2 * BW - 1);
        m_issued  = 0;
        m_recv    = 0;
        m_acc_cyc = cyc;
        m_acc_cnt++;
        for (int i = 0; i < BW; i++) begin
          exp_addr_q.push_back(m_block + 16'(2 * i));
          exp_wr_q.push_back({OFF_W'(i), mem_fn(m_block + 16'(2 * i))});
        end
      end else if (m_fill) begin
        if (m_issued < BW) m_issued++;
        if (bus.memory_data_valid) begin
          m_recv++;
          if (m_recv == BW) m_fill = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_miss(input logic [15:0] addr);
    bus.miss_detected = 1'b1;
    bus.miss_address  = addr;
    tick();
    bus.miss_detected = 1'b0;
    bus.miss_address  = 16'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((m_fill || pend_addr_q.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) fail_now({name, "_timeout"});
    check({name, "_drained"}, 32'(exp_addr_q.size() + exp_wr_q.size()), 32'd0);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    int a0;
    int n;
    bus.miss_detected = 1'b0;
    bus.miss_address  = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // 1: nominal fill, fixed latency
    data_tag = 16'hA000;
    t0 = tag_count;
    do_miss(16'h1236);
    wait_idle("t1");
    check("t1_tag_count", 32'(tag_count - t0), 32'd1);
    check("t1_tag_cycle", 32'(last_tag_cyc - m_acc_cyc), 32'd12);
    check("t1_block", 32'(bus.fill_block_addr), 32'h1230);
    check("t1_busy_after", 32'(bus.fsm_busy), 32'd0);

    // 2: top-of-memory block
    data_tag = 16'($urandom);
    t0 = tag_count;
    do_miss(16'hFFF8);
    wait_idle("t2");
    check("t2_tag_count", 32'(tag_count - t0), 32'd1);
    check("t2_block", 32'(bus.fill_block_addr), 32'hFFF0);

    // 3: miss held through the fill, address changed mid-fill
    t0 = tag_count;
    a0 = m_acc_cnt;
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h1236;
    repeat (4) tick();
    bus.miss_address  = 16'h4000;
    n = 0;
    while (m_acc_cnt < a0 + 2 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) fail_now("t3_second_accept");
    check("t3_second_gap", 32'(m_acc_cyc - last_tag_cyc), 32'd1);
    bus.miss_detected = 1'b0;
    wait_idle("t3");
    check("t3_tag_count", 32'(tag_count - t0), 32'd2);
    check("t3_block", 32'(bus.fill_block_addr), 32'h4000);

    // 4: irregular return gaps
    gap_mode = 2;
    t0 = tag_count;
    do_miss(16'h0570);
    wait_idle("t4");
    gap_mode = 0;
    check("t4_tag_count", 32'(tag_count - t0), 32'd1);
    check("t4_tag_cycle", 32'(last_tag_cyc - m_acc_cyc), 32'd16);

    // 5: reset in the middle of a fill
    t0 = tag_count;
    do_miss(16'h2468);
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check("t5_busy_now", 32'(bus.fsm_busy), 32'd0);
    check("t5_mem_en_now", 32'(bus.mem_en), 32'd0);
    check("t5_state_now", 32'(bus.fsm_state), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_idle("t5");
    check("t5_tag_count", 32'(tag_count - t0), 32'd0);
    check("t5_block", 32'(bus.fill_block_addr), 32'd0);

    // 6: stray valids while idle
    t0 = tag_count;
    for (int i = 0; i < 4; i++) begin
      inj = 1'b1;
      tick();
      inj = 1'b0;
      tick();
    end
    check("t6_tag_count", 32'(tag_count - t0), 32'd0);
    check("t6_busy", 32'(bus.fsm_busy), 32'd0);

    // Random fills
    for (int k = 0; k < 24; k++) begin
      data_tag = 16'($urandom);
      gap_mode = $urandom_range(0, 1);
      repeat ($urandom_range(0, 3)) begin
        inj = ($urandom_range(0, 3) == 0);
        tick();
        inj = 1'b0;
      end
      t0 = tag_count;
      do_miss(16'($urandom));
      wait_idle("rand");
      check("rand_tag_count", 32'(tag_count - t0), 32'd1);
    end
    gap_mode = 0;

    check("final_queues", 32'(exp_addr_q.size() + exp_wr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling engine that sits between the I-cache/D-cache and the multi-cycle main memory.
- Replaces the ideal single-cycle memories in front of the pipeline's fetch and memory stages.
- On a cache miss it stalls the pipeline, streams one cache block from memory one word at a time, writes each word into the cache data array, then writes the tag.
- One instance per cache. An arbiter outside this block serialises memory access between instances.

Parameters:
BLOCK_WORDS, 8, 16-bit words per cache block; power of two, 2..8; OFF_W = log2(BLOCK_WORDS).
MEM_LATENCY, 4, cycles from mem_en/address to the matching memory_data_valid; used by the bench model only, the FSM counts valid strobes.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
miss_detected  input  1  cache lookup missed this cycle
miss_address  input  16  byte address of the missing access
memory_data  input  16  read data returned by memory
memory_data_valid  input  1  memory_data is valid this cycle
fsm_busy  output  1  fill in progress; pipeline stall request
mem_en  output  1  read request to memory this cycle
memory_address  output  16  word-aligned read address for mem_en
write_data_array  output  1  write memory_data into the data array this cycle
write_word_offset  output  OFF_W  word index within the block for write_data_array
write_tag_array  output  1  one-cycle pulse: write tag and set valid for fill_block_addr
fill_block_addr  output  16  latched block base address (offset bits zero)
fill_data  output  16  data to write into the array (= memory_data)

Behaviour:
Reset
- rst_n low asynchronously forces: state=IDLE, issue_cnt=0, recv_cnt=0, fill_block_addr=0.
- All 1-bit outputs read 0 and memory_address reads 0.

States: IDLE, FILL.

IDLE
- mem_en=0, write_*=0.
- fsm_busy = miss_detected. This path is combinational so the pipeline stalls in the miss cycle.
- On miss_detected: latch fill_block_addr = {miss_address[15:OFF_W+1], zeros}, clear issue_cnt and recv_cnt, go to FILL next edge.
- memory_data_valid in IDLE is ignored.

FILL
- fsm_busy=1.
- Issue phase:
  - mem_en=1 while issue_cnt < BLOCK_WORDS.
  - memory_address = fill_block_addr + 2*issue_cnt.
  - issue_cnt increments each cycle mem_en=1 and saturates at BLOCK_WORDS.
  - memory_address=0 when mem_en=0.
- Receive phase (overlaps the issue phase):
  - write_data_array = memory_data_valid.
  - write_word_offset = recv_cnt[OFF_W-1:0].
  - recv_cnt increments on each valid.
- Final word (valid while recv_cnt == BLOCK_WORDS-1):
  - write_data_array and write_tag_array both assert in the same cycle.
  - Next edge: state=IDLE.
- miss_detected is ignored during FILL. A new miss is accepted only in IDLE, earliest the cycle after the final word.
- Valid strobes beyond BLOCK_WORDS cannot occur in FILL, because the FSM returns to IDLE after the final word.

Latency (defaults)
- Miss at cycle 0 → addresses issued cycles 1–8 → data valid cycles 5–12.
- write_tag_array at cycle 12; IDLE at cycle 13.
- fsm_busy high cycles 0–12.

Widths and edge cases
- Address arithmetic is 16-bit.
- A block at 0xFFF0 issues through 0xFFFE; no wrap is possible because the offset fits in the block.
- Reset mid-FILL: immediate IDLE, no tag write; any late valid strobes are ignored.

Test Plan:
1. Reset, then miss_detected=1 with miss_address=0x1236 at cycle 0; memory model with latency 4 returning 0xA000+offset.
   - Expect fsm_busy=1 in cycle 0.
   - Expect mem_en cycles 1–8 with addresses 0x1230,0x1232,…,0x123E.
   - Expect write_data_array cycles 5–12, offsets 0..7, fill_data 0xA000..0xA007.
   - Expect write_tag_array only at cycle 12, fill_block_addr=0x1230, fsm_busy=0 at cycle 13.
2. Miss at 0xFFF8 → addresses 0xFFF0..0xFFFE, no wrap; tag pulse once.
3. miss_detected held high throughout a fill, address changed to 0x4000 mid-fill → fill_block_addr stays at the first block; second fill starts the cycle after the tag pulse with base 0x4000.
4. Irregular valid gaps (valids at cycles 5,7,8,11,12,13,15,16) → offsets still 0..7 in order; tag pulse at cycle 16 only.
5. rst_n low at cycle 7 mid-fill → outputs 0 immediately, no tag pulse; stray valids afterwards → no array writes.
6. memory_data_valid pulses while IDLE with no miss → no writes, fsm_busy=0.
